mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Main control state machine for the multiple-cycle MIPS-subset CPU: the driver of the datapath ALU's 4-bit operation code and of every datapath enable/select. It sequences fetch, decode, execute, memory and write-back per instruction. It stalls on a memory-ready handshake and suppresses register write-back on signed overflow. Sits between the instruction register and the datapath.

Parameters:
ST_W, 4, state register width
WAIT_MEM, 1, 1 = fetch/memory states hold until mem_ready; 0 = ignore mem_ready (single-cycle memory)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
overflow  in  1  ALU signed overflow flag
mem_ready  in  1  memory access complete this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if branch taken (taken = zero for beq, ~zero for bne, resolved internally)
IorD  out  1  memory address: 0 PC, 1 ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegWrite  out  1  register file write
RegDst  out  2  0 rt, 1 rd, 2 $31
MemtoReg  out  2  0 ALUOut, 1 MDR, 2 PC
ALUSrcA  out  2  0 PC, 1 rs, 2 zero-extended shamt
ALUSrcB  out  2  0 rt, 1 constant 4, 2 sign-ext imm, 3 sign-ext imm<<2; andi/ori/xori use 2 with zero-extension via ext_zero
ext_zero  out  1  immediate zero-extension select
PCSource  out  2  0 ALU result, 1 ALUOut, 2 jump target, 3 rs
ALU_operation  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SRL, 0110 SUB, 0111 SLT, 1000 SLL
state  out  4  current state, debug
illegal  out  1  sticky unknown-instruction flag

Behaviour:
- Moore outputs decoded from state; only PC-taken qualification and overflow gating use inputs.
- States: IF=0, ID=1, MA=2, MR=3, LWB=4, MW=5, RX=6, RWB=7, BR=8, J=9, IX=10, IWB=11, JAL=12, JR=13, ERR=14.
- IF: MemRead, IRWrite, IorD=0, ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0, PCWrite. With WAIT_MEM=1, stay in IF while mem_ready=0; IRWrite/PCWrite asserted only in the cycle mem_ready=1. Exit to ID.
- ID: ALUSrcA=0, ALUSrcB=3, ADD (branch target to ALUOut). Dispatch:
  - lw/sw -> MA
  - R-type with funct jr -> JR; other legal funct -> RX
  - beq/bne -> BR
  - j -> J; jal -> JAL
  - addi/andi/ori/xori/slti -> IX
  - anything else -> ERR
- MA: ALUSrcA=1, ALUSrcB=2, ADD. lw -> MR, sw -> MW.
- MR: MemRead, IorD=1; waits on mem_ready like IF; then LWB.
- LWB: RegWrite, RegDst=0, MemtoReg=1 -> IF.
- MW: MemWrite, IorD=1; held until mem_ready -> IF.
- RX: ALUSrcB=0. ALUSrcA=2 for sll/srl, else 1. ALU_operation from funct: add->ADD, sub->SUB, and, or, xor, nor, slt, srl, sll. -> RWB.
- RWB: RegDst=1, MemtoReg=0, ALU_operation held from RX. RegWrite=1 unless add/sub and ovf_q=1. ovf_q is overflow registered at the end of RX/IX. -> IF.
- BR: ALUSrcA=1, ALUSrcB=0, SUB, PCSource=1, PCWriteCond. -> IF.
- J: PCSource=2, PCWrite -> IF.
- JAL: PCSource=2, PCWrite, RegWrite, RegDst=2, MemtoReg=2. PC already holds PC+4. -> IF.
- JR: PCSource=3, PCWrite -> IF.
- IX: ALUSrcA=1, ALUSrcB=2. ext_zero=1 for andi/ori/xori. ALU op: ADD/AND/OR/XOR/SLT. -> IWB.
- IWB: RegDst=0, MemtoReg=0, ALU op held. RegWrite unless addi and ovf_q. -> IF.
- ERR: illegal=1 sticky, all enables 0, stays until reset.
- Reset (rst_n=0, asynchronous): state=IF, ovf_q=0, illegal=0.
  - While rst_n=0, every write/strobe output (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) is forced 0.
  - Selects and ALU_operation are 0 during reset.
  - First fetch occurs on the first clk edge after release.
  - Reset mid-instruction aborts it with no write.
- Unused ALU_operation codes 1001-1111 never emitted.

Test Plan:
- Reset release, mem_ready=1, IR=add $3,$1,$2 (op 0, funct 100000): state 0,1,6,7,0; RWB has ALU_operation=0010, RegDst=1, RegWrite=1.
- lw with mem_ready low 3 cycles in MR: states 0,1,2,3,3,3,3,4,0; MemRead high throughout MR; RegWrite only in LWB with MemtoReg=1.
- beq with zero=1 -> PCWriteCond=1, taken, ALU_operation=0110; bne with zero=1 -> no PC load.
- addi with overflow=1 in IX -> IWB RegWrite=0. sll -> RX ALUSrcA=2, ALU_operation=1000.
- Opcode 111111 -> ERR, illegal=1 held 10 cycles, all strobes 0; rst_n pulse low mid-cycle -> immediate state=0, illegal=0.
- jal -> JAL: PCWrite=1, RegWrite=1, RegDst=2, MemtoReg=2. jr (funct 001000) -> JR with PCSource=3.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Control/status bundle between the multi-cycle CPU control FSM (master)
// and the datapath (slave). Instruction fields and ALU/memory flags flow
// into the FSM; enables, selects and the ALU operation code flow out.
interface mc_ctrl_fsm_if #(
  parameter int ST_W = 4
);
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic            zero;
  logic            overflow;
  logic            mem_ready;
  logic            PCWrite;
  logic            PCWriteCond;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            IRWrite;
  logic            RegWrite;
  logic [1:0]      RegDst;
  logic [1:0]      MemtoReg;
  logic [1:0]      ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic            ext_zero;
  logic [1:0]      PCSource;
  logic [3:0]      ALU_operation;
  logic [ST_W-1:0] state;
  logic            illegal;

  modport master (
    input  opcode, funct, zero, overflow, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ext_zero, PCSource,
           ALU_operation, state, illegal
  );

  modport slave (
    output opcode, funct, zero, overflow, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ext_zero, PCSource,
           ALU_operation, state, illegal
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS-subset CPU. Sequences fetch,
// decode, execute, memory and write-back; stalls on mem_ready in the memory
// states and suppresses write-back of add/sub/addi on signed overflow.
// Outputs are decoded from the state; while rst_n is low they are all 0.
module mc_ctrl_fsm #(
  parameter int ST_W     = 4,
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctrl_fsm_if.master bus
);

  localparam logic [ST_W-1:0] S_IF  = ST_W'(0);
  localparam logic [ST_W-1:0] S_ID  = ST_W'(1);
  localparam logic [ST_W-1:0] S_MA  = ST_W'(2);
  localparam logic [ST_W-1:0] S_MR  = ST_W'(3);
  localparam logic [ST_W-1:0] S_LWB = ST_W'(4);
  localparam logic [ST_W-1:0] S_MW  = ST_W'(5);
  localparam logic [ST_W-1:0] S_RX  = ST_W'(6);
  localparam logic [ST_W-1:0] S_RWB = ST_W'(7);
  localparam logic [ST_W-1:0] S_BR  = ST_W'(8);
  localparam logic [ST_W-1:0] S_J   = ST_W'(9);
  localparam logic [ST_W-1:0] S_IX  = ST_W'(10);
  localparam logic [ST_W-1:0] S_IWB = ST_W'(11);
  localparam logic [ST_W-1:0] S_JAL = ST_W'(12);
  localparam logic [ST_W-1:0] S_JR  = ST_W'(13);
  localparam logic [ST_W-1:0] S_ERR = ST_W'(14);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_next;
  logic            r_ovf;
  logic            r_illegal;
  logic [3:0]      r_alu_op;

  logic       w_rdy;
  logic       w_taken;
  logic [3:0] w_r_alu;
  logic       w_r_legal;
  logic       w_r_shift;
  logic       w_r_ovf_chk;
  logic [3:0] w_i_alu;
  logic       w_is_imm;
  logic       w_i_ext_zero;
  logic       w_i_ovf_chk;

  logic       w_pcw, w_pcwc, w_iord, w_mrd, w_mwr, w_irw, w_rw, w_extz;
  logic [1:0] w_regdst, w_memtoreg, w_srca, w_srcb, w_pcsrc;
  logic [3:0] w_alu;

  // With single-cycle memory every access completes immediately
  assign w_rdy   = WAIT_MEM ? bus.mem_ready : 1'b1;
  // Only beq/bne reach BR, so anything that is not bne branches on zero
  assign w_taken = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;

  // Function-field decode of R-type ALU instructions (jr handled in dispatch)
  always_comb begin
    w_r_alu     = ALU_AND;
    w_r_legal   = 1'b1;
    w_r_shift   = 1'b0;
    w_r_ovf_chk = 1'b0;
    case (bus.funct)
      F_ADD: begin w_r_alu = ALU_ADD; w_r_ovf_chk = 1'b1; end
      F_SUB: begin w_r_alu = ALU_SUB; w_r_ovf_chk = 1'b1; end
      F_AND: w_r_alu = ALU_AND;
      F_OR:  w_r_alu = ALU_OR;
      F_XOR: w_r_alu = ALU_XOR;
      F_NOR: w_r_alu = ALU_NOR;
      F_SLT: w_r_alu = ALU_SLT;
      F_SRL: begin w_r_alu = ALU_SRL; w_r_shift = 1'b1; end
      F_SLL: begin w_r_alu = ALU_SLL; w_r_shift = 1'b1; end
      default: w_r_legal = 1'b0;
    endcase
  end

  // Opcode decode of immediate ALU instructions
  always_comb begin
    w_i_alu      = ALU_ADD;
    w_is_imm     = 1'b1;
    w_i_ext_zero = 1'b0;
    w_i_ovf_chk  = 1'b0;
    case (bus.opcode)
      OP_ADDI: w_i_ovf_chk = 1'b1;
      OP_ANDI: begin w_i_alu = ALU_AND; w_i_ext_zero = 1'b1; end
      OP_ORI:  begin w_i_alu = ALU_OR;  w_i_ext_zero = 1'b1; end
      OP_XORI: begin w_i_alu = ALU_XOR; w_i_ext_zero = 1'b1; end
      OP_SLTI: w_i_alu = ALU_SLT;
      default: w_is_imm = 1'b0;
    endcase
  end

  // Next-state logic, including the decode dispatch out of ID
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IF:  if (w_rdy) w_state_next = S_ID;
      S_ID: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW) w_state_next = S_MA;
        else if (bus.opcode == OP_RTYPE) begin
          if (bus.funct == F_JR)  w_state_next = S_JR;
          else if (w_r_legal)     w_state_next = S_RX;
          else                    w_state_next = S_ERR;
        end
        else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) w_state_next = S_BR;
        else if (bus.opcode == OP_J)   w_state_next = S_J;
        else if (bus.opcode == OP_JAL) w_state_next = S_JAL;
        else if (w_is_imm)             w_state_next = S_IX;
        else                           w_state_next = S_ERR;
      end
      S_MA:  w_state_next = (bus.opcode == OP_LW) ? S_MR : S_MW;
      S_MR:  if (w_rdy) w_state_next = S_LWB;
      S_MW:  if (w_rdy) w_state_next = S_IF;
      S_RX:  w_state_next = S_RWB;
      S_IX:  w_state_next = S_IWB;
      S_LWB, S_RWB, S_IWB, S_BR, S_J, S_JAL, S_JR: w_state_next = S_IF;
      S_ERR: w_state_next = S_ERR;
      default: w_state_next = S_ERR;
    endcase
  end

  // Per-state control word before reset gating
  always_comb begin
    w_pcw = 1'b0; w_pcwc = 1'b0; w_iord = 1'b0; w_mrd = 1'b0;
    w_mwr = 1'b0; w_irw = 1'b0; w_rw = 1'b0; w_extz = 1'b0;
    w_regdst = 2'd0; w_memtoreg = 2'd0; w_srca = 2'd0; w_srcb = 2'd0;
    w_pcsrc = 2'd0; w_alu = ALU_AND;
    case (r_state)
      S_IF: begin
        w_mrd = 1'b1; w_srcb = 2'd1; w_alu = ALU_ADD;
        w_irw = w_rdy; w_pcw = w_rdy;
      end
      S_ID:  begin w_srcb = 2'd3; w_alu = ALU_ADD; end
      S_MA:  begin w_srca = 2'd1; w_srcb = 2'd2; w_alu = ALU_ADD; end
      S_MR:  begin w_mrd = 1'b1; w_iord = 1'b1; end
      S_LWB: begin w_rw = 1'b1; w_memtoreg = 2'd1; end
      S_MW:  begin w_mwr = 1'b1; w_iord = 1'b1; end
      S_RX: begin
        w_srca = w_r_shift ? 2'd2 : 2'd1;
        w_alu  = w_r_alu;
      end
      S_RWB: begin
        w_regdst = 2'd1; w_alu = r_alu_op;
        w_rw = ~(w_r_ovf_chk & r_ovf);
      end
      S_BR: begin
        w_srca = 2'd1; w_alu = ALU_SUB; w_pcsrc = 2'd1; w_pcwc = w_taken;
      end
      S_J:   begin w_pcsrc = 2'd2; w_pcw = 1'b1; end
      S_JAL: begin
        w_pcsrc = 2'd2; w_pcw = 1'b1; w_rw = 1'b1;
        w_regdst = 2'd2; w_memtoreg = 2'd2;
      end
      S_JR:  begin w_pcsrc = 2'd3; w_pcw = 1'b1; end
      S_IX: begin
        w_srca = 2'd1; w_srcb = 2'd2; w_extz = w_i_ext_zero; w_alu = w_i_alu;
      end
      S_IWB: begin
        w_alu = r_alu_op;
        w_rw  = ~(w_i_ovf_chk & r_ovf);
      end
      default: ;
    endcase
  end

  // State, overflow/ALU-op capture at end of execute, sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IF;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
      r_alu_op  <= ALU_AND;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_RX || r_state == S_IX) begin
        r_ovf    <= bus.overflow;
        r_alu_op <= w_alu;
      end
      if (w_state_next == S_ERR) r_illegal <= 1'b1;
    end
  end

  // Everything is held at 0 while reset is asserted, so no stray strobe
  // escapes during the asynchronous reset window
  assign bus.PCWrite       = rst_n & w_pcw;
  assign bus.PCWriteCond   = rst_n & w_pcwc;
  assign bus.IorD          = rst_n & w_iord;
  assign bus.MemRead       = rst_n & w_mrd;
  assign bus.MemWrite      = rst_n & w_mwr;
  assign bus.IRWrite       = rst_n & w_irw;
  assign bus.RegWrite      = rst_n & w_rw;
  assign bus.ext_zero      = rst_n & w_extz;
  assign bus.RegDst        = rst_n ? w_regdst   : 2'd0;
  assign bus.MemtoReg      = rst_n ? w_memtoreg : 2'd0;
  assign bus.ALUSrcA       = rst_n ? w_srca     : 2'd0;
  assign bus.ALUSrcB       = rst_n ? w_srcb     : 2'd0;
  assign bus.PCSource      = rst_n ? w_pcsrc    : 2'd0;
  assign bus.ALU_operation = rst_n ? w_alu      : 4'd0;
  assign bus.state         = r_state;
  assign bus.illegal       = r_illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm. A per-instruction reference model turns
// each instruction (plus stall counts and flag values) into the expected
// cycle-by-cycle control words; the driver applies the inputs and queues the
// expectations, and an independent monitor compares on every falling edge.
module tb_mc_ctrl_fsm;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mc_ctrl_fsm_if #(.ST_W(4)) bus ();
  mc_ctrl_fsm #(.ST_W(4), .WAIT_MEM(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_ADD = 4'd2, A_XOR = 4'd3,
                         A_NOR = 4'd4, A_SRL = 4'd5, A_SUB = 4'd6, A_SLT = 4'd7,
                         A_SLL = 4'd8;
  localparam int NT = 21;

  typedef struct packed {
    logic [3:0] state;
    logic       illegal;
    logic       pcw, pcwc, iord, mrd, mwr, irw, rw, extz;
    logic [1:0] regdst, memtoreg, srca, srcb, pcsrc;
    logic [3:0] alu;
  } ctl_t;

  typedef struct {
    logic       rst_n;
    logic [5:0] op, fn;
    logic       zero, ovf, rdy;
    ctl_t       exp;
    string      tag;
  } cyc_t;

  typedef struct {
    ctl_t  exp;
    string tag;
  } chk_t;

  typedef enum int {K_R, K_SH, K_JR, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_I, K_BAD} kind_e;

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    kind_e      kind;
    logic [3:0] alu;
    bit         ovfc;
    bit         ez;
  } ins_t;

  ins_t tbl[NT];
  chk_t exp_q[$];
  cyc_t seq_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic put(input int i, input string n, input logic [5:0] op, input logic [5:0] fn,
                     input kind_e k, input logic [3:0] alu, input bit ovfc, input bit ez);
    tbl[i].name = n; tbl[i].op = op; tbl[i].fn = fn; tbl[i].kind = k;
    tbl[i].alu = alu; tbl[i].ovfc = ovfc; tbl[i].ez = ez;
  endtask

  function automatic int idx_of(input string n);
    for (int i = 0; i < NT; i++) if (tbl[i].name == n) return i;
    return -1;
  endfunction

  function automatic int lookup(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < NT; i++)
      if (tbl[i].op == op && (op != 6'd0 || tbl[i].fn == fn)) return i;
    return -1;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t ph(input int st);
    ctl_t c;
    c = '0;
    c.state = 4'(st);
    return c;
  endfunction

  task automatic add_cyc(input ctl_t c, input string tag, input logic [5:0] op,
                         input logic [5:0] fn, input logic zv, input logic ov, input logic rdy);
    cyc_t y;
    y.rst_n = 1'b1; y.op = op; y.fn = fn; y.zero = zv; y.ovf = ov; y.rdy = rdy;
    y.exp = c; y.tag = tag;
    seq_q.push_back(y);
  endtask

  // Reference model: expected cycle sequence of one instruction
  task automatic build(input int idx, input logic [5:0] op, input logic [5:0] fn,
                       input int if_st, input int mem_st, input logic zv, input logic ov);
    ctl_t  c;
    ins_t  t;
    kind_e k;
    string nm;
    t = tbl[0];
    k = K_BAD;
    nm = "bad";
    if (idx >= 0) begin t = tbl[idx]; k = t.kind; nm = t.name; end
    seq_q.delete();
    for (int s = 0; s <= if_st; s++) begin
      c = ph(0); c.mrd = 1; c.srcb = 2'd1; c.alu = A_ADD;
      c.irw = (s == if_st); c.pcw = (s == if_st);
      add_cyc(c, {nm, "/IF"}, op, fn, rb(), rb(), s == if_st);
    end
    c = ph(1); c.srcb = 2'd3; c.alu = A_ADD;
    add_cyc(c, {nm, "/ID"}, op, fn, rb(), rb(), rb());
    case (k)
      K_LW, K_SW: begin
        c = ph(2); c.srca = 2'd1; c.srcb = 2'd2; c.alu = A_ADD;
        add_cyc(c, {nm, "/MA"}, op, fn, rb(), rb(), rb());
        for (int s = 0; s <= mem_st; s++) begin
          if (k == K_LW) begin c = ph(3); c.mrd = 1; end
          else begin c = ph(5); c.mwr = 1; end
          c.iord = 1;
          add_cyc(c, {nm, "/MEM"}, op, fn, rb(), rb(), s == mem_st);
        end
        if (k == K_LW) begin
          c = ph(4); c.rw = 1; c.memtoreg = 2'd1;
          add_cyc(c, {nm, "/LWB"}, op, fn, rb(), rb(), rb());
        end
      end
      K_R, K_SH: begin
        c = ph(6); c.srca = (k == K_SH) ? 2'd2 : 2'd1; c.alu = t.alu;
        add_cyc(c, {nm, "/RX"}, op, fn, rb(), ov, rb());
        c = ph(7); c.regdst = 2'd1; c.alu = t.alu; c.rw = !(t.ovfc && ov);
        add_cyc(c, {nm, "/RWB"}, op, fn, rb(), rb(), rb());
      end
      K_JR: begin
        c = ph(13); c.pcsrc = 2'd3; c.pcw = 1;
        add_cyc(c, {nm, "/JR"}, op, fn, rb(), rb(), rb());
      end
      K_BEQ, K_BNE: begin
        c = ph(8); c.srca = 2'd1; c.alu = A_SUB; c.pcsrc = 2'd1;
        c.pcwc = (k == K_BEQ) ? zv : !zv;
        add_cyc(c, {nm, "/BR"}, op, fn, zv, rb(), rb());
      end
      K_J: begin
        c = ph(9); c.pcsrc = 2'd2; c.pcw = 1;
        add_cyc(c, {nm, "/J"}, op, fn, rb(), rb(), rb());
      end
      K_JAL: begin
        c = ph(12); c.pcsrc = 2'd2; c.pcw = 1; c.rw = 1; c.regdst = 2'd2; c.memtoreg = 2'd2;
        add_cyc(c, {nm, "/JAL"}, op, fn, rb(), rb(), rb());
      end
      K_I: begin
        c = ph(10); c.srca = 2'd1; c.srcb = 2'd2; c.extz = t.ez; c.alu = t.alu;
        add_cyc(c, {nm, "/IX"}, op, fn, rb(), ov, rb());
        c = ph(11); c.alu = t.alu; c.rw = !(t.ovfc && ov);
        add_cyc(c, {nm, "/IWB"}, op, fn, rb(), rb(), rb());
      end
      default: begin
        for (int s = 0; s < 10; s++) begin
          c = ph(14); c.illegal = 1;
          add_cyc(c, {nm, "/ERR"}, op, fn, rb(), rb(), rb());
        end
      end
    endcase
  endtask

  task automatic drive(input cyc_t y);
    chk_t k;
    @(posedge clk);
    #1;
    rst_n         = y.rst_n;
    bus.opcode    = y.op;
    bus.funct     = y.fn;
    bus.zero      = y.zero;
    bus.overflow  = y.ovf;
    bus.mem_ready = y.rdy;
    k.exp = y.exp;
    k.tag = y.tag;
    exp_q.push_back(k);
  endtask

  // Two cycles of reset asserted between clock edges; everything reads 0
  task automatic reset_pulse();
    cyc_t y;
    y.op = 6'($urandom); y.fn = 6'($urandom); y.zero = rb(); y.ovf = rb(); y.rdy = rb();
    y.rst_n = 1'b0; y.exp = ph(0); y.tag = "reset";
    drive(y);
    drive(y);
  endtask

  task automatic run(input int idx, input logic [5:0] op, input logic [5:0] fn, input int if_st,
                     input int mem_st, input logic zv, input logic ov, input int abort_at);
    int n;
    bit cut;
    build(idx, op, fn, if_st, mem_st, zv, ov);
    n = seq_q.size();
    cut = (abort_at > 0 && abort_at < n);
    if (cut) n = abort_at;
    for (int i = 0; i < n; i++) drive(seq_q[i]);
    $display("instr %-5s op=%b fn=%b stall_if=%0d stall_mem=%0d zero=%0b ovf=%0b cycles=%0d%s",
             (idx >= 0) ? tbl[idx].name : "bad", op, fn, if_st, mem_st, zv, ov, n,
             cut ? " aborted by reset" : "");
    if (cut || idx < 0) reset_pulse();
  endtask

  task automatic run_named(input string n, input int if_st, input int mem_st,
                           input logic zv, input logic ov, input int abort_at);
    int i;
    i = idx_of(n);
    run(i, tbl[i].op, tbl[i].fn, if_st, mem_st, zv, ov, abort_at);
  endtask

  // Monitor: one expected control word per cycle, compared mid-cycle
  initial begin
    chk_t k;
    ctl_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        k = exp_q.pop_front();
        a = {bus.state, bus.illegal, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
             bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ext_zero, bus.RegDst, bus.MemtoReg,
             bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALU_operation};
        checks++;
        if (a !== k.exp) begin
          errors++;
          $display("FAIL %s: got ctl=%h (state %0d) want ctl=%h (state %0d)",
                   k.tag, a, a.state, k.exp, k.exp.state);
        end
      end
    end
  end

  initial begin
    int idx;
    logic [5:0] op, fn;
    put(0,  "add",  6'h00, 6'h20, K_R,   A_ADD, 1, 0);
    put(1,  "sub",  6'h00, 6'h22, K_R,   A_SUB, 1, 0);
    put(2,  "and",  6'h00, 6'h24, K_R,   A_AND, 0, 0);
    put(3,  "or",   6'h00, 6'h25, K_R,   A_OR,  0, 0);
    put(4,  "xor",  6'h00, 6'h26, K_R,   A_XOR, 0, 0);
    put(5,  "nor",  6'h00, 6'h27, K_R,   A_NOR, 0, 0);
    put(6,  "slt",  6'h00, 6'h2a, K_R,   A_SLT, 0, 0);
    put(7,  "srl",  6'h00, 6'h02, K_SH,  A_SRL, 0, 0);
    put(8,  "sll",  6'h00, 6'h00, K_SH,  A_SLL, 0, 0);
    put(9,  "jr",   6'h00, 6'h08, K_JR,  A_AND, 0, 0);
    put(10, "lw",   6'h23, 6'h00, K_LW,  A_AND, 0, 0);
    put(11, "sw",   6'h2b, 6'h00, K_SW,  A_AND, 0, 0);
    put(12, "beq",  6'h04, 6'h00, K_BEQ, A_AND, 0, 0);
    put(13, "bne",  6'h05, 6'h00, K_BNE, A_AND, 0, 0);
    put(14, "j",    6'h02, 6'h00, K_J,   A_AND, 0, 0);
    put(15, "jal",  6'h03, 6'h00, K_JAL, A_AND, 0, 0);
    put(16, "addi", 6'h08, 6'h00, K_I,   A_ADD, 1, 0);
    put(17, "andi", 6'h0c, 6'h00, K_I,   A_AND, 0, 1);
    put(18, "ori",  6'h0d, 6'h00, K_I,   A_OR,  0, 1);
    put(19, "xori", 6'h0e, 6'h00, K_I,   A_XOR, 0, 1);
    put(20, "slti", 6'h0a, 6'h00, K_I,   A_SLT, 0, 0);

    bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
    bus.overflow = 1'b0; bus.mem_ready = 1'b0;
    reset_pulse();

    run_named("add",  0, 0, 1'b0, 1'b0, 0);
    run_named("lw",   0, 3, 1'b0, 1'b0, 0);
    run_named("beq",  0, 0, 1'b1, 1'b0, 0);
    run_named("bne",  0, 0, 1'b1, 1'b0, 0);
    run_named("bne",  1, 0, 1'b0, 1'b0, 0);
    run_named("addi", 0, 0, 1'b0, 1'b1, 0);
    run_named("sll",  2, 0, 1'b0, 1'b0, 0);
    run(-1, 6'h3f, 6'h00, 0, 0, 1'b0, 1'b0, 0);
    run_named("jal",  0, 0, 1'b0, 1'b0, 0);
    run_named("jr",   0, 0, 1'b0, 1'b0, 0);
    run_named("sub",  0, 0, 1'b0, 1'b1, 0);
    run_named("sw",   1, 2, 1'b0, 1'b0, 0);
    run_named("andi", 0, 0, 1'b0, 1'b1, 0);
    run_named("add",  0, 0, 1'b0, 1'b0, 3);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom); fn = 6'($urandom);
        idx = lookup(op, fn);
      end else begin
        idx = $urandom_range(0, NT - 1);
        op = tbl[idx].op; fn = tbl[idx].fn;
      end
      run(idx, op, fn, $urandom_range(0, 2), $urandom_range(0, 2), rb(), rb(),
          ($urandom_range(0, 11) == 0) ? $urandom_range(1, 4) : 0);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles never compared, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
